// File: rtl/hsid_pkg.sv
// Shared types and default widths for the hyperspectral distance blocks.
// Holds the squared-accumulator state enum and the default element/band widths.
package hsid_pkg;

  localparam int HSID_DATA_WIDTH = 16;
  localparam int HSID_BAND_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } hsid_sq_acc_state_t;

endpackage

// File: rtl/hsid_sq_acc.sv
// Squared-difference accumulator: sums band_count samples into one distance.
// Ports: clk, rst_n (sync, active-low), clear, start, band_count,
//   sq_df_in/sq_df_valid/sq_df_ready (input stream),
//   acc_out/acc_valid/acc_ready (result handshake), busy.
module hsid_sq_acc
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH = HSID_DATA_WIDTH,
  parameter int BAND_WIDTH = HSID_BAND_WIDTH,
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + BAND_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    start,
  input  logic [BAND_WIDTH-1:0]   band_count,
  input  logic [2*DATA_WIDTH-1:0] sq_df_in,
  input  logic                    sq_df_valid,
  output logic                    sq_df_ready,
  output logic [ACC_WIDTH-1:0]    acc_out,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    busy
);

  hsid_sq_acc_state_t state;
  hsid_sq_acc_state_t state_nxt;

  logic [BAND_WIDTH-1:0] cnt;
  logic [BAND_WIDTH-1:0] cnt_inc;
  logic [BAND_WIDTH-1:0] bands;
  logic                  accept;
  logic                  last;
  logic                  launch;

  assign accept  = sq_df_valid & (state == S_ACC);
  assign cnt_inc = cnt + BAND_WIDTH'(1);
  assign last    = (cnt_inc == bands);
  assign launch  = start & (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = (band_count == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (accept && last) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (acc_ready) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sq_df_ready = (state == S_ACC);
    acc_valid   = (state == S_DONE);
    busy        = (state != S_IDLE);
  end

  // acc_out is the running sum itself; it is only meaningful with acc_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_out <= '0;
      cnt     <= '0;
      bands   <= '0;
    end else if (clear) begin
      acc_out <= '0;
      cnt     <= '0;
    end else if (launch) begin
      acc_out <= '0;
      cnt     <= '0;
      bands   <= band_count;
    end else if (accept) begin
      acc_out <= acc_out + ACC_WIDTH'(sq_df_in);
      cnt     <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_hsid_sq_acc.sv
// Self-checking bench for hsid_sq_acc with a transaction-level model.
// Directed scenarios plus randomized traffic, checked every cycle.
module tb_hsid_sq_acc;
  import hsid_pkg::*;

  localparam int DW = 16;
  localparam int BW = 8;
  localparam int AW = 2 * DW + BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          start;
  logic [BW-1:0] band_count;
  logic [2*DW-1:0] sq_df_in;
  logic          sq_df_valid;
  logic          sq_df_ready;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 = waiting, 1 = collecting, 2 = result held
  int          m_mode = 0;
  logic [AW-1:0] m_sum = '0;
  int          m_left = 0;

  always #5 clk = ~clk;

  hsid_sq_acc #(.DATA_WIDTH(DW), .BAND_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .band_count(band_count), .sq_df_in(sq_df_in),
    .sq_df_valid(sq_df_valid), .sq_df_ready(sq_df_ready),
    .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    if (!rst_n || clear) begin
      m_mode = 0;
      m_sum  = '0;
      m_left = 0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_sum  = '0;
        m_left = int'(band_count);
        m_mode = (band_count == 0) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (sq_df_valid) begin
        m_sum  = m_sum + AW'(sq_df_in);
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 2;
      end
    end else begin
      if (acc_ready) m_mode = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("acc_valid", 64'(acc_valid), 64'(m_mode == 2));
    chk("sq_df_ready", 64'(sq_df_ready), 64'(m_mode == 1));
    chk("busy", 64'(busy), 64'(m_mode != 0));
    chk("acc_out", 64'(acc_out), 64'(m_sum));
  endtask

  task automatic idle_in();
    rst_n = 1'b1; clear = 1'b0; start = 1'b0;
    sq_df_valid = 1'b0; acc_ready = 1'b0;
  endtask

  task automatic go(input int bc);
    idle_in();
    start = 1'b1;
    band_count = BW'(bc);
    tick();
    start = 1'b0;
  endtask

  // Feed samples with valid held high until the model leaves collecting.
  task automatic feed(input logic [31:0] s[$]);
    int i = 0;
    int guard = 0;
    while (m_mode == 1 && guard < 300) begin
      sq_df_valid = 1'b1;
      sq_df_in = (i < s.size()) ? s[i] : 32'h0;
      tick();
      i++;
      guard++;
    end
    sq_df_valid = 1'b0;
    if (guard >= 300) chk("feed_timeout", 64'(guard), 64'(0));
  endtask

  task automatic drain();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    int          bc;
    int          guard;
    int          accepted;
    logic [AW-1:0] hand;

    idle_in();
    band_count = '0;
    sq_df_in = '0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_acc_out", 64'(acc_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // four bands, 1+4+9+16
    go(4);
    q = '{32'd1, 32'd4, 32'd9, 32'd16};
    feed(q);
    chk("b4_valid", 64'(acc_valid), 64'h1);
    chk("b4_sum", 64'(acc_out), 64'd30);
    drain();

    // large samples, result held while acc_ready low
    go(3);
    q = '{32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001};
    feed(q);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("b3_hold", 64'(acc_out), 64'h2_FFFA_0003);
    end
    drain();
    chk("b3_idle", 64'(busy), 64'h0);
    chk("b3_novalid", 64'(acc_valid), 64'h0);

    // zero bands: result immediately
    go(0);
    chk("b0_valid", 64'(acc_valid), 64'h1);
    chk("b0_sum", 64'(acc_out), 64'h0);
    drain();

    // clear after two accepts, then a fresh vector
    go(5);
    sq_df_valid = 1'b1;
    sq_df_in = 32'd100;
    tick();
    tick();
    sq_df_valid = 1'b0;
    clear = 1'b1;
    acc_ready = 1'b1;
    tick();
    clear = 1'b0;
    acc_ready = 1'b0;
    chk("clr_busy", 64'(busy), 64'h0);
    chk("clr_sum", 64'(acc_out), 64'h0);
    tick();
    chk("clr_novalid", 64'(acc_valid), 64'h0);
    go(2);
    q = '{32'd7, 32'd8};
    feed(q);
    chk("b2_sum", 64'(acc_out), 64'd15);
    drain();

    // randomized traffic with stray starts, then back-to-back starts
    for (int v = 0; v < 40; v++) begin
      bc = $urandom_range(1, 7);
      go(bc);
      hand = '0;
      accepted = 0;
      guard = 0;
      while (m_mode == 1 && guard < 400) begin
        sq_df_valid = 1'($urandom_range(0, 1));
        sq_df_in = $urandom;
        start = ($urandom_range(0, 3) == 0);
        band_count = BW'($urandom_range(0, 255));
        if (sq_df_valid) begin
          hand = hand + AW'(sq_df_in);
          accepted++;
        end
        tick();
        guard++;
      end
      if (guard >= 400) chk("rand_timeout", 64'(guard), 64'(0));
      chk("rand_count", 64'(accepted), 64'(bc));
      chk("rand_sum", 64'(acc_out), 64'(hand));
      sq_df_valid = 1'b1;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        start = 1'b1;
        tick();
      end
      start = 1'b0;
      sq_df_valid = 1'b0;
      chk("rand_held", 64'(acc_out), 64'(hand));
      drain();
    end

    // reset in the middle of a vector
    go(6);
    sq_df_valid = 1'b1;
    sq_df_in = 32'd55;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sum", 64'(acc_out), 64'h0);
    chk("mid_rst_ready", 64'(sq_df_ready), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_valid", 64'(acc_valid), 64'h0);
    rst_n = 1'b1;
    sq_df_valid = 1'b0;
    tick();
    go(2);
    q = '{32'd3, 32'd4};
    feed(q);
    chk("post_rst_sum", 64'(acc_out), 64'd7);
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
